// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl
// Instruction-fetch sequencer for inst_mem. Owns the program counter, issues
// one read per cycle, captures each returned word with its address into a
// 2-entry buffer and hands instructions to decode over valid/ready. A redirect
// (or reset) reloads the PC and discards everything buffered or in flight.
//
// Ports
//   clk            : single clock, all state on rising edge
//   reset_b        : synchronous, active-high reset (same effect as redirect to RESET_PC)
//   imem_addr      : read address to inst_mem, straight from the PC register
//   imem_data      : inst_mem read data, valid one cycle after imem_addr
//   enable         : allows new fetches to issue
//   redirect_valid : one-cycle pulse loading redirect_pc into the PC
//   redirect_pc    : redirect target word address
//   out_valid      : buffer head holds an instruction
//   out_ready      : decode accepts the head this cycle
//   out_inst       : instruction at buffer head (0 when empty)
//   out_pc         : word address of out_inst (0 when empty)
//   idle           : nothing in flight and buffer empty
module imem_fetch_ctrl #(
    parameter int          ADDR_W   = 10,
    parameter int          DATA_W   = 32,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset_b,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    input  logic              enable,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_pc,
    output logic              idle
);

    localparam logic [ADDR_W-1:0] RESET_PC_A = ADDR_W'(RESET_PC);

    // Control state
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              req_pending_q, req_pending_d;
    logic [1:0]        count_q, count_d;

    // Datapath state (no reset needed: masked by count_q / req_pending_q)
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic [DATA_W-1:0] inst_q [2];
    logic [DATA_W-1:0] inst_d [2];
    logic [ADDR_W-1:0] ipc_q  [2];
    logic [ADDR_W-1:0] ipc_d  [2];

    logic [2:0] occ;
    logic       pop;
    logic       push;
    logic       issue;

    // Words already buffered plus the one that will land next edge.
    assign occ  = {1'b0, count_q} + {2'b00, req_pending_q};
    assign out_valid = (count_q != 2'd0);
    assign pop  = out_valid & out_ready;
    assign push = req_pending_q & ~redirect_valid;
    // Issue only when the returning word is guaranteed a free slot; a pop this
    // cycle frees one, which keeps the stream gap-free under full occupancy.
    assign issue = enable & ~redirect_valid &
                   ((occ < 3'd2) | ((occ == 3'd2) & pop));

    assign imem_addr = pc_q;
    assign out_inst  = out_valid ? inst_q[0] : '0;
    assign out_pc    = out_valid ? ipc_q[0]  : '0;
    assign idle      = (occ == 3'd0);

    always_comb begin
        pc_d          = pc_q;
        req_pending_d = 1'b0;
        req_pc_d      = req_pc_q;
        count_d       = count_q;
        inst_d        = inst_q;
        ipc_d         = ipc_q;

        if (redirect_valid) begin
            // Redirect drops the in-flight word and any offered head.
            pc_d    = redirect_pc;
            count_d = 2'd0;
        end else begin
            if (issue) begin
                req_pc_d      = pc_q;
                pc_d          = pc_q + ADDR_W'(1);
                req_pending_d = 1'b1;
            end

            if (push && pop) begin
                if (count_q == 2'd1) begin
                    inst_d[0] = imem_data;
                    ipc_d[0]  = req_pc_q;
                end else begin
                    inst_d[0] = inst_q[1];
                    ipc_d[0]  = ipc_q[1];
                    inst_d[1] = imem_data;
                    ipc_d[1]  = req_pc_q;
                end
            end else if (push) begin
                if (count_q == 2'd0) begin
                    inst_d[0] = imem_data;
                    ipc_d[0]  = req_pc_q;
                end else begin
                    inst_d[1] = imem_data;
                    ipc_d[1]  = req_pc_q;
                end
                count_d = count_q + 2'd1;
            end else if (pop) begin
                inst_d[0] = inst_q[1];
                ipc_d[0]  = ipc_q[1];
                count_d   = count_q - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_b) begin
            pc_q          <= RESET_PC_A;
            req_pending_q <= 1'b0;
            count_q       <= 2'd0;
        end else begin
            pc_q          <= pc_d;
            req_pending_q <= req_pending_d;
            count_q       <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        req_pc_q <= req_pc_d;
        inst_q   <= inst_d;
        ipc_q    <= ipc_d;
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
module tb_imem_fetch_ctrl;

    localparam int          ADDR_W   = 10;
    localparam int          DATA_W   = 32;
    localparam int unsigned RESET_PC = 0;

    logic              clk = 1'b0;
    logic              reset_b = 1'b1;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_data = '0;
    logic              enable = 1'b0;
    logic              redirect_valid = 1'b0;
    logic [ADDR_W-1:0] redirect_pc = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_inst;
    logic [ADDR_W-1:0] out_pc;
    logic              idle;

    int n_tests = 0;
    int n_fail  = 0;

    logic [ADDR_W-1:0] exp_q [$];

    imem_fetch_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset_b(reset_b), .imem_addr(imem_addr), .imem_data(imem_data),
        .enable(enable), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_pc(out_pc), .idle(idle)
    );

    always #5 clk = ~clk;

    // Memory model: word k holds 0xA000_0000 + k, one-cycle read latency.
    always @(posedge clk) imem_data <= 32'hA000_0000 + 32'(imem_addr);

    // Load the scoreboard with the sequential stream starting at start.
    task automatic expect_from(input logic [ADDR_W-1:0] start);
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(start + ADDR_W'(i));
    endtask

    // Scoreboard and handshake-stability monitor.
    logic              prev_hold = 1'b0;
    logic [ADDR_W-1:0] prev_pc;
    logic [DATA_W-1:0] prev_inst;
    always @(negedge clk) begin
        logic [ADDR_W-1:0] e;
        if (!reset_b && !redirect_valid && prev_hold) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_pc !== prev_pc || out_inst !== prev_inst) begin
                n_fail++;
                $display("FAIL hold_stable: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                         out_valid, out_pc, out_inst, prev_pc, prev_inst);
            end
        end
        if (!reset_b && !redirect_valid && out_valid === 1'b1 && out_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty: got pc=%h want no delivery", out_pc);
            end else begin
                e = exp_q.pop_front();
                if (out_pc !== e || out_inst !== (32'hA000_0000 + 32'(e))) begin
                    n_fail++;
                    $display("FAIL stream: got pc=%h inst=%h want pc=%h inst=%h",
                             out_pc, out_inst, e, 32'hA000_0000 + 32'(e));
                end
            end
        end
        prev_hold = !reset_b && !redirect_valid && out_valid === 1'b1 && !out_ready;
        prev_pc   = out_pc;
        prev_inst = out_inst;
    end

    // The issue rule must never let a response land in a full buffer.
    always @(posedge clk) begin
        if (!reset_b && !redirect_valid && dut.req_pending_q === 1'b1 &&
            dut.count_q === 2'd2 && !(out_valid && out_ready)) begin
            n_fail++;
            $display("FAIL push_full: got push into count=2 want none");
        end
    end

    task automatic test_reset;
        reset_b = 1'b1; enable = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (imem_addr !== ADDR_W'(RESET_PC)) begin n_fail++; $display("FAIL reset_addr: got %h want %h", imem_addr, ADDR_W'(RESET_PC)); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_tests++; if (out_inst !== '0) begin n_fail++; $display("FAIL reset_inst: got %h want 0", out_inst); end
        n_tests++; if (out_pc !== '0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", out_pc); end
        n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b want 1", idle); end
        n_tests++; if (dut.count_q !== 2'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", dut.count_q); end
        expect_from(ADDR_W'(RESET_PC));
        reset_b = 1'b0;
        @(posedge clk); #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL latency_e1: got %b want 0", out_valid); end
        @(posedge clk); #1;
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL latency_e2: got %b want 1", out_valid); end
        n_tests++; if (out_pc !== ADDR_W'(RESET_PC)) begin n_fail++; $display("FAIL first_pc: got %h want %h", out_pc, ADDR_W'(RESET_PC)); end
    endtask

    task automatic test_stream;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_tests++;
            if (out_valid !== 1'b1) begin n_fail++; $display("FAIL throughput: cycle %0d got %b want 1", i, out_valid); end
        end
    endtask

    task automatic test_backpressure;
        logic [ADDR_W-1:0] a0;
        a0 = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (i == 1) a0 = imem_addr;
            if (i == 5) begin
                n_tests++; if (dut.count_q !== 2'd2) begin n_fail++; $display("FAIL bp_count: got %0d want 2", dut.count_q); end
                n_tests++; if (imem_addr !== a0) begin n_fail++; $display("FAIL bp_addr_freeze: got %h want %h", imem_addr, a0); end
            end
        end
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_resume: got %b want 1", out_valid); end
    endtask

    task automatic test_redirect;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (dut.count_q !== 2'd2) begin n_fail++; $display("FAIL redir_pre_count: got %0d want 2", dut.count_q); end
        redirect_valid = 1'b1; redirect_pc = 10'h155; out_ready = 1'b1;
        expect_from(10'h155);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_gap1: got %b want 0", out_valid); end
        @(posedge clk); #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_gap2: got %b want 0", out_valid); end
        @(posedge clk); #1;
        n_tests++; if (out_valid !== 1'b1 || out_pc !== 10'h155) begin n_fail++; $display("FAIL redir_first: got v=%b pc=%h want v=1 pc=155", out_valid, out_pc); end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_wrap;
        logic [ADDR_W-1:0] got  [8];
        logic [ADDR_W-1:0] want [4];
        int n;
        want = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        n = 0;
        redirect_valid = 1'b1; redirect_pc = 10'h3FE; out_ready = 1'b1;
        expect_from(10'h3FE);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1 && out_ready) begin got[n] = out_pc; n++; end
        end
        n_tests++;
        if (n < 4) begin
            n_fail++; $display("FAIL wrap_count: got %0d want >=4", n);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (got[i] !== want[i]) begin n_fail++; $display("FAIL wrap_seq[%0d]: got %h want %h", i, got[i], want[i]); end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_enable;
        logic [ADDR_W-1:0] a0;
        a0 = '0;
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                a0 = imem_addr;
                n_tests++; if (idle !== 1'b0) begin n_fail++; $display("FAIL en_inflight_idle: got %b want 0", idle); end
            end
            if (i == 3) begin
                n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL en_idle: got %b want 1", idle); end
                n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL en_drained: got %b want 0", out_valid); end
                n_tests++; if (imem_addr !== a0) begin n_fail++; $display("FAIL en_addr_hold: got %h want %h", imem_addr, a0); end
            end
        end
        enable = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL en_resume: got %b want 1", out_valid); end
    endtask

    task automatic test_reset_redirect;
        bit seen;
        seen = 1'b0;
        reset_b = 1'b1; redirect_valid = 1'b1; redirect_pc = 10'h200;
        expect_from(ADDR_W'(RESET_PC));
        @(posedge clk); #1;
        reset_b = 1'b0; redirect_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstredir_valid: got %b want 0", out_valid); end
        n_tests++; if (imem_addr !== ADDR_W'(RESET_PC)) begin n_fail++; $display("FAIL rstredir_addr: got %h want %h", imem_addr, ADDR_W'(RESET_PC)); end
        for (int i = 0; i < 6 && !seen; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        n_tests++;
        if (!seen) begin
            n_fail++; $display("FAIL rstredir_timeout: got no valid want valid within 6 cycles");
        end else if (out_pc !== ADDR_W'(RESET_PC)) begin
            n_fail++; $display("FAIL rstredir_first: got %h want %h", out_pc, ADDR_W'(RESET_PC));
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_redirect_disabled;
        enable = 1'b0; redirect_valid = 1'b1; redirect_pc = 10'h0AA;
        expect_from(10'h0AA);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        n_tests++; if (imem_addr !== 10'h0AA) begin n_fail++; $display("FAIL redis_addr: got %h want 0aa", imem_addr); end
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL redis_idle: got %b want 1", idle); end
        enable = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL redis_resume: got %b want 1", out_valid); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_enable();
        test_reset_redirect();
        test_redirect_disabled();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
